// File: rtl/tx_side_sequencer.sv
// ---------------------------------------------------------------------------
// tx_side_sequencer
//   Tracks a ring of data sides between a writer (fills sides) and a
//   transmitter (drains sides). The ring length is a runtime limit loaded on
//   clear, clamped to 1..NUM_SIDES.
//
// Ports
//   clk           system clock, all state on rising edge
//   rst           synchronous active-high reset (limit -> NUM_SIDES)
//   clear         synchronous soft clear, reloads limit from active_sides
//   active_sides  requested ring length, sampled only on clear
//   push          writer filled the side at tail_side
//   pop           transmitter consumed the side at head_side
//   head_side     next side to transmit
//   tail_side     next side to fill
//   occupancy     filled, untransmitted sides
//   full / empty  occupancy == limit / occupancy == 0 (registered)
//   head_wrap     one-cycle pulse after head wraps to 0
//   overflow      sticky: a push was rejected
//   underflow     sticky: a pop was rejected
// ---------------------------------------------------------------------------
module tx_side_sequencer #(
   parameter int NUM_SIDES = 4,
   parameter int IDX_W     = $clog2(NUM_SIDES),
   parameter int CNT_W     = IDX_W + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic [CNT_W-1:0] active_sides,
   input  logic             push,
   input  logic             pop,
   output logic [IDX_W-1:0] head_side,
   output logic [IDX_W-1:0] tail_side,
   output logic [CNT_W-1:0] occupancy,
   output logic             full,
   output logic             empty,
   output logic             head_wrap,
   output logic             overflow,
   output logic             underflow
);

   localparam logic [CNT_W-1:0] MAX_LIM = CNT_W'(NUM_SIDES);

   logic [CNT_W-1:0] limit;
   logic [CNT_W-1:0] occ_nxt;
   logic             push_ok;
   logic             pop_ok;
   logic             head_at_end;

   // Acceptance uses the registered flags so nothing combinational reaches
   // the outputs from push/pop.
   assign push_ok     = push & ~full;
   assign pop_ok      = pop & ~empty;
   assign head_at_end = (CNT_W'(head_side) == limit - CNT_W'(1));

   always_comb begin
      occ_nxt = occupancy;
      if (push_ok && !pop_ok)
         occ_nxt = occupancy + CNT_W'(1);
      else if (!push_ok && pop_ok)
         occ_nxt = occupancy - CNT_W'(1);
   end

   // Advance a pointer modulo the runtime limit; with limit 1 it stays at 0.
   function automatic logic [IDX_W-1:0] bump(input logic [IDX_W-1:0] p,
                                             input logic [CNT_W-1:0] lim);
      if (CNT_W'(p) == lim - CNT_W'(1))
         return '0;
      else
         return p + IDX_W'(1);
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         limit     <= MAX_LIM;
         head_side <= '0;
         tail_side <= '0;
         occupancy <= '0;
         full      <= 1'b0;
         empty     <= 1'b1;
         head_wrap <= 1'b0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else if (clear) begin
         // Out-of-range requests (0 or above NUM_SIDES) fall back to the max.
         limit     <= (active_sides != '0 && active_sides <= MAX_LIM) ?
                      active_sides : MAX_LIM;
         head_side <= '0;
         tail_side <= '0;
         occupancy <= '0;
         full      <= 1'b0;
         empty     <= 1'b1;
         head_wrap <= 1'b0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (push_ok) tail_side <= bump(tail_side, limit);
         if (pop_ok)  head_side <= bump(head_side, limit);
         occupancy <= occ_nxt;
         full      <= (occ_nxt == limit);
         empty     <= (occ_nxt == '0);
         head_wrap <= pop_ok & head_at_end;
         if (push && full)  overflow  <= 1'b1;
         if (pop  && empty) underflow <= 1'b1;
      end
   end

endmodule

// File: tb/tb_tx_side_sequencer.sv
// ---------------------------------------------------------------------------
// tb_tx_side_sequencer
//   Directed bench for tx_side_sequencer (NUM_SIDES=4). A queue-free ring
//   model written with modulo arithmetic is compared against every output
//   after every clock; literal checks pin the model on the key scenarios.
// ---------------------------------------------------------------------------
module tb_tx_side_sequencer;

   localparam int NS    = 4;
   localparam int IDX_W = $clog2(NS);
   localparam int CNT_W = IDX_W + 1;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             clear = 1'b0;
   logic [CNT_W-1:0] active_sides = '0;
   logic             push = 1'b0;
   logic             pop = 1'b0;
   logic [IDX_W-1:0] head_side;
   logic [IDX_W-1:0] tail_side;
   logic [CNT_W-1:0] occupancy;
   logic             full;
   logic             empty;
   logic             head_wrap;
   logic             overflow;
   logic             underflow;

   int total = 0;
   int bad   = 0;

   // behavioural model state
   int m_lim = NS, m_head = 0, m_tail = 0, m_occ = 0;
   bit m_wrap = 0, m_ovf = 0, m_unf = 0;

   tx_side_sequencer #(.NUM_SIDES(NS)) dut (
      .clk(clk), .rst(rst), .clear(clear), .active_sides(active_sides),
      .push(push), .pop(pop), .head_side(head_side), .tail_side(tail_side),
      .occupancy(occupancy), .full(full), .empty(empty),
      .head_wrap(head_wrap), .overflow(overflow), .underflow(underflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", nm, act, exp);
      end
   endtask

   // Ring semantics straight from the rules: accept on not-full / not-empty,
   // pointers advance modulo the limit, rejects set sticky flags.
   task automatic model_update();
      bit pa, qa;
      if (rst || clear) begin
         if (rst) m_lim = NS;
         else     m_lim = (active_sides >= 1 && active_sides <= NS) ? int'(active_sides) : NS;
         m_head = 0; m_tail = 0; m_occ = 0;
         m_wrap = 0; m_ovf = 0; m_unf = 0;
      end else begin
         pa = push && (m_occ != m_lim);
         qa = pop && (m_occ != 0);
         m_wrap = qa && (m_head == m_lim - 1);
         if (push && !pa) m_ovf = 1;
         if (pop && !qa)  m_unf = 1;
         if (pa) m_tail = (m_tail + 1) % m_lim;
         if (qa) m_head = (m_head + 1) % m_lim;
         m_occ = m_occ + int'(pa) - int'(qa);
      end
   endtask

   task automatic compare();
      chk("head_side", int'(head_side), m_head);
      chk("tail_side", int'(tail_side), m_tail);
      chk("occupancy", int'(occupancy), m_occ);
      chk("full",      int'(full),      int'(m_occ == m_lim));
      chk("empty",     int'(empty),     int'(m_occ == 0));
      chk("head_wrap", int'(head_wrap), int'(m_wrap));
      chk("overflow",  int'(overflow),  int'(m_ovf));
      chk("underflow", int'(underflow), int'(m_unf));
   endtask

   // One clock: drive, edge, model, sample 1 time unit after the edge.
   task automatic step(input logic p, input logic q);
      push = p;
      pop  = q;
      @(posedge clk);
      model_update();
      #1;
      compare();
      push = 1'b0;
      pop  = 1'b0;
   endtask

   task automatic do_rst();
      rst = 1'b1;
      step(1'b0, 1'b0);
      rst = 1'b0;
   endtask

   // Push/pop held high during clear must be ignored without raising flags.
   task automatic do_clear(input int n);
      clear = 1'b1;
      active_sides = CNT_W'(n);
      step(1'b1, 1'b1);
      clear = 1'b0;
      active_sides = '0;
   endtask

   initial begin
      #2;
      // reset state
      do_rst();
      chk("rst_occ", int'(occupancy), 0);
      chk("rst_empty", int'(empty), 1);
      chk("rst_full", int'(full), 0);

      // four pushes: tail 1,2,3,0 then full
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 1'b0);
         chk("push_tail", int'(tail_side), (i + 1) % 4);
      end
      chk("fill_occ", int'(occupancy), 4);
      chk("fill_full", int'(full), 1);
      chk("fill_empty", int'(empty), 0);
      chk("fill_ovf", int'(overflow), 0);

      // four pops: head 1,2,3,0, wrap only on the last
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 1'b1);
         chk("pop_head", int'(head_side), (i + 1) % 4);
         chk("pop_wrap", int'(head_wrap), (i == 3) ? 1 : 0);
      end
      chk("drain_empty", int'(empty), 1);
      step(1'b0, 1'b0);
      chk("wrap_pulse_end", int'(head_wrap), 0);

      // full with push+pop: push dropped, pop taken
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
      step(1'b1, 1'b1);
      chk("pp_full_ovf", int'(overflow), 1);
      chk("pp_full_occ", int'(occupancy), 3);
      chk("pp_full_head", int'(head_side), 1);
      chk("pp_full_tail", int'(tail_side), 0);

      // empty with push+pop: pop dropped, push taken
      do_rst();
      step(1'b1, 1'b1);
      chk("pp_empty_unf", int'(underflow), 1);
      chk("pp_empty_occ", int'(occupancy), 1);
      chk("pp_empty_tail", int'(tail_side), 1);
      chk("pp_empty_head", int'(head_side), 0);

      // reset mid-operation with occupancy 2 and overflow set
      do_rst();
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
      step(1'b1, 1'b1);
      step(1'b0, 1'b1);
      chk("pre_rst_occ", int'(occupancy), 2);
      chk("pre_rst_ovf", int'(overflow), 1);
      do_rst();
      chk("mid_rst_occ", int'(occupancy), 0);
      chk("mid_rst_ovf", int'(overflow), 0);
      chk("mid_rst_head", int'(head_side), 0);
      step(1'b1, 1'b0);
      chk("post_rst_occ", int'(occupancy), 1);

      // limit 3: alternating push/pop, wrap on third pop
      do_clear(3);
      chk("clr_ovf", int'(overflow), 0);
      chk("clr_unf", int'(underflow), 0);
      chk("clr_occ", int'(occupancy), 0);
      for (int i = 0; i < 5; i++) begin
         step(1'b1, 1'b0);
         chk("l3_tail", int'(tail_side), (i + 1) % 3);
         step(1'b0, 1'b1);
         chk("l3_head", int'(head_side), (i + 1) % 3);
         chk("l3_wrap", int'(head_wrap), (i == 2) ? 1 : 0);
      end
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
      chk("l3_full", int'(full), 1);

      // active_sides 0 and 7 both clamp to 4
      do_clear(0);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
      chk("l0_not_full3", int'(full), 0);
      step(1'b1, 1'b0);
      chk("l0_full4", int'(full), 1);
      do_clear(7);
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
      chk("l7_full4", int'(full), 1);
      chk("l7_tail", int'(tail_side), 0);

      // limit 1: pointers stuck at 0, every pop wraps
      do_clear(1);
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 1'b0);
         chk("l1_full", int'(full), 1);
         chk("l1_tail", int'(tail_side), 0);
         step(1'b0, 1'b1);
         chk("l1_wrap", int'(head_wrap), 1);
         chk("l1_head", int'(head_side), 0);
      end

      // mixed traffic at limit 2 and full range, checked by the model only
      do_clear(2);
      for (int i = 0; i < 40; i++) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      do_rst();
      for (int i = 0; i < 60; i++) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/tx_side_sequencer.md
TX_SIDE_SEQUENCER -- requirements
Module: tx_side_sequencer

Interface
REQ-001 Parameter NUM_SIDES, default 4, number of data sides tracked; legal 2..16.
REQ-002 Parameter IDX_W, default $clog2(NUM_SIDES), side-index width.
REQ-003 Parameter CNT_W, default IDX_W+1, occupancy/limit width.
REQ-004 Port clk  input  1  single system clock, all state on rising edge.
REQ-005 Port rst  input  1  reset: one clock; reset is synchronous and active-high.
REQ-006 Port clear  input  1  synchronous soft clear; reloads side limit.
REQ-007 Port active_sides  input  CNT_W  number of sides in use, sampled only on clear.
REQ-008 Port push  input  1  writer has filled side at tail_side.
REQ-009 Port pop  input  1  transmitter has consumed side at head_side.
REQ-010 Port head_side  output  IDX_W  next side to transmit.
REQ-011 Port tail_side  output  IDX_W  next side to fill.
REQ-012 Port occupancy  output  CNT_W  count of filled, untransmitted sides.
REQ-013 Port full  output  1  occupancy equals side limit.
REQ-014 Port empty  output  1  occupancy equals zero.
REQ-015 Port head_wrap  output  1  one-cycle pulse, head wrapped to 0.
REQ-016 Port overflow  output  1  sticky, push rejected.
REQ-017 Port underflow  output  1  sticky, pop rejected.

Function
REQ-018 Internal limit register (CNT_W) SHALL define wrap point; pointers SHALL count 0..limit-1 then wrap to 0.
REQ-019 On clear, limit SHALL load active_sides if 1 <= active_sides <= NUM_SIDES, else NUM_SIDES (clamp).
REQ-020 Priority SHALL be rst > clear > push/pop; push/pop in a clear cycle SHALL be ignored, no error flags.
REQ-021 Push SHALL be accepted iff full is 0 in that cycle (registered full); pop accepted iff empty is 0.
REQ-022 Accepted push SHALL advance tail_side by 1 modulo limit next cycle.
REQ-023 Accepted pop SHALL advance head_side by 1 modulo limit next cycle.
REQ-024 occupancy SHALL be +1 on push-only accept, -1 on pop-only accept, unchanged on both or neither.
REQ-025 Push while full SHALL be dropped and set overflow next cycle, even with simultaneous pop; the pop is still accepted.
REQ-026 Pop while empty SHALL be dropped and set underflow next cycle; a simultaneous push is still accepted.
REQ-027 overflow/underflow SHALL stay set until rst or clear.
REQ-028 full and empty SHALL be registered, updated in the same cycle as occupancy, never both 1.
REQ-029 head_wrap SHALL be 1 for exactly the cycle after an accepted pop with head_side = limit-1; 0 otherwise.
REQ-030 With limit = 1, head_side and tail_side SHALL stay 0 and every accepted pop SHALL pulse head_wrap.
REQ-031 Outputs SHALL be glitch-free register outputs; no combinational input-to-output path.
REQ-032 Implementation SHALL be a single-clock design with no latches.

Reset
REQ-033 While rst is 1 at a clock edge: head_side=0, tail_side=0, occupancy=0, empty=1, full=0, head_wrap=0, overflow=0, underflow=0, limit=NUM_SIDES.
REQ-034 rst mid-operation SHALL discard all occupancy and pending flags; first cycle after deassert SHALL accept push.
REQ-035 clear SHALL produce the same output values as rst except limit per REQ-019.

Verification
REQ-036 Reset, 4 pushes (NUM_SIDES=4) -> tail_side 1,2,3,0; occupancy 4; full=1, empty=0; overflow=0.
REQ-037 From full, 4 pops -> head_side 1,2,3,0; head_wrap pulse on 4th pop only; empty=1.
REQ-038 Full, push+pop same cycle -> overflow=1 next cycle, occupancy 3, head_side 1, tail_side unchanged.
REQ-039 Empty, push+pop same cycle -> underflow=1, occupancy 1, tail_side 1, head_side 0.
REQ-040 clear with active_sides=3, then 5 push/pop pairs -> pointers sequence 0,1,2,0,1,2; head_wrap at 3rd pop; clear with active_sides=0 -> limit 4.
REQ-041 rst asserted at occupancy 2 with overflow set -> next cycle all REQ-033 values; push next cycle -> occupancy 1.
